ovsf_despreader: RTL and testbench

Receive-side OVSF despreader: correlates an incoming stream of signed chip samples against the OVSF code selected by spreading-factor index `sf` and code number `k`, and emits one signed symbol sum per SF chips. It sits after chip-rate sample alignment and before symbol demapping. It is the counterpart of the transmit-side `ovsf` code generator and uses the identical code definition, so a chip stream spread with (SF, K) despreads to full gain here.

---
 rtl/ovsf_pkg.sv | 38 +++
 rtl/ovsf_code_bit.sv | 14 +
 rtl/ovsf_despreader.sv | 119 +++++++++++
 tb/tb_ovsf_despreader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ovsf_pkg.sv
// rtl/ovsf_pkg.sv - shared OVSF spreading-factor constants and code helpers
// Used by both the receive despreader and the transmit code generator.
package ovsf_pkg;

  localparam logic [2:0] SF4_IDX   = 3'd0;
  localparam logic [2:0] SF8_IDX   = 3'd1;
  localparam logic [2:0] SF16_IDX  = 3'd2;
  localparam logic [2:0] SF32_IDX  = 3'd3;
  localparam logic [2:0] SF64_IDX  = 3'd4;
  localparam logic [2:0] SF128_IDX = 3'd5;
  localparam logic [2:0] SF256_IDX = 3'd6;
  localparam logic [2:0] SF512_IDX = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } desp_state_t;

  function automatic logic [9:0] sf_len(input logic [2:0] sf);
    return 10'd4 << sf;
  endfunction

  function automatic logic [8:0] sf_last(input logic [2:0] sf);
    logic [9:0] len_m1;
    len_m1 = sf_len(sf) - 10'd1;
    return len_m1[8:0];
  endfunction

  // Reverse all 9 bits, then shift down so only k[sf+1:0] survives, reversed over sf+2 bits.
  function automatic logic [8:0] ovsf_bitrev(input logic [8:0] k, input logic [2:0] sf);
    logic [8:0] rev9;
    for (int i = 0; i < 9; i++) begin
      rev9[i] = k[8-i];
    end
    return rev9 >> (3'd7 - sf);
  endfunction

endpackage

// File: rtl/ovsf_code_bit.sv
// rtl/ovsf_code_bit.sv - combinational OVSF code bit c(n) for a given (sf, k)
// c=1 means the chip is multiplied by -1.
module ovsf_code_bit
  import ovsf_pkg::*;
(
  input  logic [2:0] sf,
  input  logic [8:0] k,
  input  logic [8:0] n,
  output logic       c
);

  assign c = ^(ovsf_bitrev(k, sf) & n);

endmodule

// File: rtl/ovsf_despreader.sv
// rtl/ovsf_despreader.sv - correlates signed chips against an OVSF code, one sum per SF chips
// Holds the FSM, chip counter, config latch, accumulator and registered outputs.
module ovsf_despreader
  import ovsf_pkg::*;
#(
  parameter int CHIP_W = 8,
  parameter int ACC_W  = CHIP_W + 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sf,
  input  logic [8:0]        k,
  input  logic              chip_valid,
  input  logic [CHIP_W-1:0] chip_in,
  input  logic              sync,
  output logic              sym_valid,
  output logic [ACC_W-1:0]  sym_data,
  output logic              sym_abort,
  output logic              busy
);

  desp_state_t state, state_next;

  logic        accept;
  logic        chip0;
  logic        abort;
  logic        last;
  logic        code;
  logic [8:0]  n;
  logic [8:0]  n_eff;
  logic [8:0]  n_next;
  logic [2:0]  sf_q;
  logic [8:0]  k_q;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] chip_ext;
  logic signed [ACC_W-1:0] term;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A sync chip always restarts the symbol; in RUN a non-zero count means a partial is dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    chip0      = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (chip_valid && sync) begin
          state_next = ST_RUN;
          accept     = 1'b1;
          chip0      = 1'b1;
        end
      end
      ST_RUN: begin
        if (chip_valid) begin
          accept = 1'b1;
          chip0  = sync || (n == 9'd0);
          abort  = sync && (n != 9'd0);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);

  // Chip 0 always has c=0, so the stale latched config is harmless on that chip.
  ovsf_code_bit u_code_bit (
    .sf (sf_q),
    .k  (k_q),
    .n  (n_eff),
    .c  (code)
  );

  always_comb begin
    n_eff    = chip0 ? 9'd0 : n;
    last     = !chip0 && (n == sf_last(sf_q));
    chip_ext = {{(ACC_W-CHIP_W){chip_in[CHIP_W-1]}}, chip_in};
    term     = code ? -chip_ext : chip_ext;
    acc_next = chip0 ? term : acc + term;
    n_next   = last ? 9'd0 : n_eff + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n         <= 9'd0;
      acc       <= '0;
      sf_q      <= SF4_IDX;
      k_q       <= 9'd0;
      sym_valid <= 1'b0;
      sym_abort <= 1'b0;
      sym_data  <= '0;
    end else begin
      sym_valid <= 1'b0;
      sym_abort <= abort;
      if (accept) begin
        n   <= n_next;
        acc <= acc_next;
        if (chip0) begin
          sf_q <= sf;
          k_q  <= k;
        end
        if (last) begin
          sym_valid <= 1'b1;
          sym_data  <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ovsf_despreader.sv
// tb/tb_ovsf_despreader.sv - self-checking bench for ovsf_despreader
// Reference model builds codes with the recursive OVSF tree and correlates whole symbols.
module tb_ovsf_despreader;
  import ovsf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sf;
  logic [8:0]  k;
  logic        chip_valid;
  logic [7:0]  chip_in;
  logic        sync;
  logic        sym_valid;
  logic [17:0] sym_data;
  logic        sym_abort;
  logic        busy;

  ovsf_despreader #(.CHIP_W(8), .ACC_W(18)) dut (
    .clk        (clk),
    .reset      (reset),
    .sf         (sf),
    .k          (k),
    .chip_valid (chip_valid),
    .chip_in    (chip_in),
    .sync       (sync),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_abort  (sym_abort),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_run;
  int m_sf, m_k;
  int mq[$];
  bit exp_valid, exp_abort;
  int exp_data;
  int accepted;
  int n_valid_seen, n_abort_seen;
  int pulse_data[$];
  int pulse_pos[$];

  typedef struct packed {
    int sfi;
    int kk;
    int c0;
    int c1;
    int c2;
    int c3;
    int expv;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // OVSF tree: C(2N,2j)=[C,C], C(2N,2j+1)=[C,-C]; root-first uses the MSB of k.
  function automatic int model_sum(input int q[$], input int sfi, input int kk);
    int c[512];
    int len;
    int s;
    c[0] = 1;
    len  = 1;
    for (int j = sfi + 1; j >= 0; j--) begin
      for (int i = 0; i < len; i++) c[len+i] = ((kk >> j) & 1) ? -c[i] : c[i];
      len = len * 2;
    end
    s = 0;
    for (int i = 0; i < q.size(); i++) s += q[i] * c[i];
    return s;
  endfunction

  task automatic step(input bit v, input bit s, input int d);
    int act;
    chip_valid = v;
    sync       = s;
    chip_in    = d[7:0];
    exp_valid  = 1'b0;
    exp_abort  = 1'b0;
    if (v && (m_run || s)) begin
      if (s && m_run && mq.size() != 0) begin
        exp_abort = 1'b1;
        mq.delete();
      end
      m_run = 1'b1;
      if (mq.size() == 0) begin
        m_sf = int'(sf);
        m_k  = int'(k);
      end
      mq.push_back(d);
      accepted++;
      if (mq.size() == (4 << m_sf)) begin
        exp_valid = 1'b1;
        exp_data  = model_sum(mq, m_sf, m_k);
        mq.delete();
      end
    end
    @(posedge clk);
    #1;
    act = int'($signed(sym_data));
    check("sym_valid", int'(sym_valid), int'(exp_valid));
    check("sym_abort", int'(sym_abort), int'(exp_abort));
    check("sym_data", act, exp_data);
    check("busy", int'(busy), int'(m_run));
    if (sym_valid) begin
      n_valid_seen++;
      pulse_data.push_back(act);
      pulse_pos.push_back(accepted);
    end
    if (sym_abort) n_abort_seen++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_run    = 1'b0;
    mq.delete();
    exp_data = 0;
    check("rst_valid", int'(sym_valid), 0);
    check("rst_abort", int'(sym_abort), 0);
    check("rst_data", int'(sym_data), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
  endtask

  initial begin
    int v0, a0, gap;
    reset      = 1'b1;
    sf         = SF4_IDX;
    k          = 9'd0;
    chip_valid = 1'b0;
    chip_in    = 8'd0;
    sync       = 1'b0;
    m_run      = 1'b0;
    exp_data   = 0;
    accepted   = 0;
    n_valid_seen = 0;
    n_abort_seen = 0;
    @(posedge clk);
    do_reset();

    tbl[0] = '{0, 0, 10, 10, 10, 10, 40};
    tbl[1] = '{0, 1, 5, 5, -5, -5, 20};
    tbl[2] = '{0, 2, 5, 5, -5, -5, 0};
    tbl[3] = '{0, 3, 1, 2, 3, 4, 0};
    tbl[4] = '{0, 1, -128, -128, 127, 127, -510};
    for (int i = 0; i < 5; i++) begin
      sf = tbl[i].sfi[2:0];
      k  = tbl[i].kk[8:0];
      a0 = n_abort_seen;
      step(1'b1, 1'b1, tbl[i].c0);
      step(1'b1, 1'b0, tbl[i].c1);
      step(1'b1, 1'b0, tbl[i].c2);
      step(1'b1, 1'b0, tbl[i].c3);
      check("tbl_valid", int'(sym_valid), 1);
      check("tbl_data", int'($signed(sym_data)), tbl[i].expv);
      check("tbl_no_abort", n_abort_seen - a0, 0);
    end

    // SF512 extremes, back to back
    sf = SF512_IDX;
    k  = 9'd0;
    v0 = n_valid_seen;
    step(1'b1, 1'b1, -128);
    for (int i = 1; i < 512; i++) step(1'b1, 1'b0, -128);
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 127);
    check("sf512_pulses", n_valid_seen - v0, 2);
    if (n_valid_seen - v0 == 2) begin
      check("sf512_neg", pulse_data[pulse_data.size()-2], -65536);
      check("sf512_pos", pulse_data[pulse_data.size()-1], 65024);
      check("sf512_spacing", pulse_pos[pulse_pos.size()-1] - pulse_pos[pulse_pos.size()-2], 512);
    end

    // mid-symbol sync at SF8
    sf = SF8_IDX;
    k  = 9'd0;
    v0 = n_valid_seen;
    a0 = n_abort_seen;
    step(1'b1, 1'b1, 7);
    step(1'b1, 1'b0, 7);
    step(1'b1, 1'b0, 7);
    step(1'b1, 1'b1, 1);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 1);
    check("midsync_aborts", n_abort_seen - a0, 1);
    check("midsync_valids", n_valid_seen - v0, 1);
    check("midsync_data", pulse_data[pulse_data.size()-1], 8);

    // config change mid-symbol plus random gaps
    k  = 9'd0;
    v0 = n_valid_seen;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) k = 9'd3;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 0);
      step(1'b1, (i == 0), 1);
    end
    check("cfg_valids", n_valid_seen - v0, 2);
    if (n_valid_seen - v0 == 2) begin
      check("cfg_first", pulse_data[pulse_data.size()-2], 8);
      check("cfg_second", pulse_data[pulse_data.size()-1], 0);
    end

    // reset at chip 5 of an SF16 symbol
    sf = SF16_IDX;
    k  = 9'd0;
    step(1'b1, 1'b1, 3);
    for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 3);
    chip_valid = 1'b1;
    do_reset();
    v0 = n_valid_seen;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 5);
    check("post_rst_quiet", n_valid_seen - v0, 0);
    step(1'b1, 1'b1, 2);
    for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 2);
    check("post_rst_data", pulse_data[pulse_data.size()-1], 32);

    // random stream: config and sync randomized every cycle
    for (int i = 0; i < 3000; i++) begin
      sf = 3'($urandom_range(0, 4));
      k  = 9'($urandom);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           int'($urandom_range(0, 255)) - 128);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
